// File: rtl/vga_box_pkg.sv
// Shared constants, palette and the per-axis reflection step for the box bouncer.
package vga_box_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam logic [5:0] PALETTE [4] = '{6'b111111, 6'b110000, 6'b001100, 6'b111100};
  localparam logic [5:0] BORDER_COLOUR = 6'b000011;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_step_t;

  // All arithmetic is 11 bits wide so pos+size+speed can exceed the screen without wrapping.
  function automatic axis_step_t axis_step(input logic [9:0]  pos,
                                           input logic        dir,
                                           input logic [10:0] spd,
                                           input logic [10:0] res,
                                           input logic [10:0] size);
    axis_step_t  r;
    logic [10:0] pos_w;
    pos_w = {1'b0, pos};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (spd != 11'd0) begin
      if (dir == DIR_POS) begin
        if (pos_w + size + spd >= res) begin
          r.pos = 10'(res - size);
          r.dir = DIR_NEG;
          r.hit = 1'b1;
        end else begin
          r.pos = 10'(pos_w + spd);
        end
      end else begin
        if (pos_w < spd) begin
          r.pos = '0;
          r.dir = DIR_POS;
          r.hit = 1'b1;
        end else begin
          r.pos = 10'(pos_w - spd);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_bouncer_motion.sv
// Position, direction and colour index of one box; advances only on update.
module vga_box_motion
  import vga_box_pkg::*;
#(
  parameter int         H_RES    = H_RES_DEF,
  parameter int         V_RES    = V_RES_DEF,
  parameter int         BOX_SIZE = 64,
  parameter int         SPEED_W  = 4,
  parameter logic [9:0] X_INIT   = 10'd0,
  parameter logic [9:0] Y_INIT   = 10'd0,
  parameter logic       DX_INIT  = DIR_POS,
  parameter logic       DY_INIT  = DIR_POS,
  parameter logic [1:0] COL_INIT = 2'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update,
  input  logic [SPEED_W-1:0] speed,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic [1:0]         colour,
  output logic               bounced
);

  logic       dx;
  logic       dy;
  axis_step_t step_x;
  axis_step_t step_y;

  always_comb begin
    step_x = axis_step(x, dx, 11'(speed), 11'(H_RES), 11'(BOX_SIZE));
    step_y = axis_step(y, dy, 11'(speed), 11'(V_RES), 11'(BOX_SIZE));
  end

  // A corner hit reflects both axes but still counts as a single bounce.
  assign bounced = update & (step_x.hit | step_y.hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= X_INIT;
      y      <= Y_INIT;
      dx     <= DX_INIT;
      dy     <= DY_INIT;
      colour <= COL_INIT;
    end else if (update) begin
      x  <= step_x.pos;
      y  <= step_y.pos;
      dx <= step_x.dir;
      dy <= step_y.dir;
      if (step_x.hit | step_y.hit) colour <= colour + 2'd1;
    end
  end

endmodule

// File: rtl/vga_box_bouncer.sv
// Bouncing-box overlay: frame tick and divider, per-box motion, priority pixel mux
// and registered outputs with sync lines delayed to match the pixel latency.
module vga_box_bouncer
  import vga_box_pkg::*;
#(
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int BOX_SIZE  = 64,
  parameter int NUM_BOXES = 2,
  parameter int FRAME_DIV = 1,
  parameter int BORDER    = 2,
  parameter int SPEED_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               video_active,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  output logic [5:0]         rgb,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               bounce
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  logic                 vsync_d;
  logic                 tick;
  logic                 update;
  logic [3:0]           div_cnt;
  logic [9:0]           box_x   [NUM_BOXES];
  logic [9:0]           box_y   [NUM_BOXES];
  logic [1:0]           box_col [NUM_BOXES];
  logic [NUM_BOXES-1:0] box_bounced;
  logic [NUM_BOXES-1:0] in_box;
  logic                 in_border;
  logic [5:0]           rgb_next;

  assign tick   = vsync_in & ~vsync_d;
  assign update = tick & ~pause & (div_cnt == DIV_LAST);

  // Ticks seen while paused are dropped; the divider simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      div_cnt <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (tick & ~pause) div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end
  end

  for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
    vga_box_motion #(
      .H_RES    (H_RES),
      .V_RES    (V_RES),
      .BOX_SIZE (BOX_SIZE),
      .SPEED_W  (SPEED_W),
      .X_INIT   (10'(2 * i * BOX_SIZE)),
      .Y_INIT   (10'(i * BOX_SIZE)),
      .DX_INIT  (((i % 2) == 1) ? DIR_NEG : DIR_POS),
      .DY_INIT  (DIR_POS),
      .COL_INIT (2'(i))
    ) u_motion (
      .clk     (clk),
      .rst_n   (rst_n),
      .update  (update),
      .speed   (speed),
      .x       (box_x[i]),
      .y       (box_y[i]),
      .colour  (box_col[i]),
      .bounced (box_bounced[i])
    );

    assign in_box[i] = ({1'b0, pix_x} >= {1'b0, box_x[i]}) &&
                       ({1'b0, pix_x} <  {1'b0, box_x[i]} + 11'(BOX_SIZE)) &&
                       ({1'b0, pix_y} >= {1'b0, box_y[i]}) &&
                       ({1'b0, pix_y} <  {1'b0, box_y[i]} + 11'(BOX_SIZE));
  end

  assign in_border = (pix_x < 10'(BORDER)) || (pix_x >= 10'(H_RES - BORDER)) ||
                     (pix_y < 10'(BORDER)) || (pix_y >= 10'(V_RES - BORDER));

  // Walk from the highest index down so the lowest-index box wins.
  always_comb begin
    rgb_next = '0;
    if (video_active) begin
      if (in_border) rgb_next = BORDER_COLOUR;
      for (int i = NUM_BOXES - 1; i >= 0; i--) begin
        if (in_box[i]) rgb_next = PALETTE[box_col[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      bounce    <= 1'b0;
    end else begin
      rgb       <= rgb_next;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      bounce    <= |box_bounced;
    end
  end

endmodule

// File: tb/tb_vga_box_bouncer.sv
// Directed bench: default instance for motion/pixel checks, a square FRAME_DIV=3 instance
// for divider, pause and corner bounces, and a short-screen instance for box overlap.
module tb_vga_box_bouncer;

  localparam logic [5:0] WHITE  = 6'b111111;
  localparam logic [5:0] RED    = 6'b110000;
  localparam logic [5:0] GREEN  = 6'b001100;
  localparam logic [5:0] YELLOW = 6'b111100;
  localparam logic [5:0] BRD    = 6'b000011;

  logic       clk;
  logic       rst_n;
  logic       hsync_in;
  logic       video_active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [3:0] speed;
  logic       pause;
  logic       vsync_a, vsync_b, vsync_c;
  logic [5:0] rgb_a, rgb_b, rgb_c;
  logic       hs_a, hs_b, hs_c;
  logic       vs_a, vs_b, vs_c;
  logic       bounce_a, bounce_b, bounce_c;

  int   checks;
  int   errors;
  logic b1, b2, v1;

  vga_box_bouncer dut_a (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_a),
    .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .speed(speed),
    .pause(pause), .rgb(rgb_a), .hsync_out(hs_a), .vsync_out(vs_a), .bounce(bounce_a)
  );

  vga_box_bouncer #(.H_RES(480), .V_RES(480), .NUM_BOXES(1), .FRAME_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_b),
    .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .speed(speed),
    .pause(pause), .rgb(rgb_b), .hsync_out(hs_b), .vsync_out(vs_b), .bounce(bounce_b)
  );

  vga_box_bouncer #(.V_RES(192)) dut_c (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_c),
    .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .speed(speed),
    .pause(pause), .rgb(rgb_c), .hsync_out(hs_c), .vsync_out(vs_c), .bounce(bounce_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One vsync pulse on the chosen instance; returns bounce in the two cycles after the tick.
  task automatic frame(input int which, output logic fb1, output logic fb2, output logic fv1);
    case (which)
      0:       vsync_a = 1'b1;
      1:       vsync_b = 1'b1;
      default: vsync_c = 1'b1;
    endcase
    @(negedge clk);
    case (which)
      0:       begin fb1 = bounce_a; fv1 = vs_a; end
      1:       begin fb1 = bounce_b; fv1 = vs_b; end
      default: begin fb1 = bounce_c; fv1 = vs_c; end
    endcase
    @(negedge clk);
    case (which)
      0:       fb2 = bounce_a;
      1:       fb2 = bounce_b;
      default: fb2 = bounce_c;
    endcase
    vsync_a = 1'b0;
    vsync_b = 1'b0;
    vsync_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input int which, input int px, input int py, input logic va,
                       output logic [5:0] val);
    pix_x        = 10'(px);
    pix_y        = 10'(py);
    video_active = va;
    @(negedge clk);
    case (which)
      0:       val = rgb_a;
      1:       val = rgb_b;
      default: val = rgb_c;
    endcase
  endtask

  task automatic pix_chk(input string tag, input int which, input int px, input int py,
                         input logic [5:0] exp);
    logic [5:0] v;
    probe(which, px, py, 1'b1, v);
    chk(tag, 32'(v), 32'(exp));
  endtask

  task automatic box_b_chk(input string tag, input int pos);
    pix_chk({tag, "_in"},  1, pos + 63, pos + 32, WHITE);
    pix_chk({tag, "_out"}, 1, pos + 64, pos + 32, 6'b000000);
  endtask

  initial begin
    logic [5:0] v;
    clk = 1'b0; rst_n = 1'b0; hsync_in = 1'b1; video_active = 1'b1;
    pix_x = '0; pix_y = '0; speed = '0; pause = 1'b0;
    vsync_a = 1'b0; vsync_b = 1'b0; vsync_c = 1'b0;
    checks = 0; errors = 0;

    // Reset: inputs would otherwise produce nonzero outputs.
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(rgb_a), 0);
    chk("rst_hsync", 32'(hs_a), 0);
    chk("rst_vsync", 32'(vs_a), 0);
    chk("rst_bounce", 32'(bounce_a), 0);
    hsync_in = 1'b0;
    video_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pix_chk("a_box0_origin", 0, 0, 0, WHITE);
    pix_chk("a_box0_far", 0, 63, 63, WHITE);
    pix_chk("a_box0_right", 0, 64, 32, 6'b000000);
    pix_chk("a_box1_corner", 0, 128, 64, RED);
    pix_chk("a_box1_left", 0, 127, 70, 6'b000000);
    pix_chk("a_box1_above", 0, 130, 63, 6'b000000);
    chk("a_bounce_idle", 32'(bounce_a), 0);

    hsync_in = 1'b1;
    #1 chk("hsync_d_pre", 32'(hs_a), 0);
    @(negedge clk);
    chk("hsync_d_hi", 32'(hs_a), 1);
    hsync_in = 1'b0;
    @(negedge clk);
    chk("hsync_d_lo", 32'(hs_a), 0);

    // Divider of 3 with speed 2, then pause holding position and count.
    speed = 4'd2;
    for (int t = 1; t <= 4; t++) begin
      frame(1, b1, b2, v1);
      chk($sformatf("b_div_bounce_t%0d", t), 32'(b1), 0);
      box_b_chk($sformatf("b_div_pos_t%0d", t), (t >= 3) ? 2 : 0);
    end
    pause = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      frame(1, b1, b2, v1);
      chk($sformatf("b_pause_bounce_t%0d", t), 32'(b1), 0);
    end
    box_b_chk("b_pause_pos", 2);
    pause = 1'b0;
    frame(1, b1, b2, v1);
    box_b_chk("b_unpause1_pos", 2);
    frame(1, b1, b2, v1);
    box_b_chk("b_unpause2_pos", 4);

    // Square screen: both axes reach the wall on the same update.
    speed = 4'd15;
    for (int u = 1; u <= 28; u++) begin
      for (int f = 1; f <= 3; f++) begin
        frame(1, b1, b2, v1);
        chk($sformatf("b_corner_hi_u%0d_f%0d", u, f), 32'(b1), 32'(u == 28 && f == 3));
        if (u == 28 && f == 3) chk("b_corner_hi_pulse_end", 32'(b2), 0);
      end
    end
    pix_chk("b_corner_hi_in", 1, 416, 440, RED);
    pix_chk("b_corner_hi_left", 1, 415, 440, 6'b000000);
    pix_chk("b_corner_hi_above", 1, 420, 415, 6'b000000);
    pix_chk("b_corner_hi_over_border", 1, 479, 479, RED);
    for (int u = 1; u <= 28; u++) begin
      for (int f = 1; f <= 3; f++) begin
        frame(1, b1, b2, v1);
        chk($sformatf("b_corner_lo_u%0d_f%0d", u, f), 32'(b1), 32'(u == 28 && f == 3));
        if (u == 28 && f == 3) chk("b_corner_lo_pulse_end", 32'(b2), 0);
      end
    end
    pix_chk("b_corner_lo_origin", 1, 0, 0, GREEN);
    pix_chk("b_corner_lo_far", 1, 63, 63, GREEN);
    pix_chk("b_corner_lo_right", 1, 64, 32, 6'b000000);
    pix_chk("b_border_left", 1, 1, 100, BRD);

    speed = 4'd0;
    for (int f = 1; f <= 3; f++) begin
      frame(1, b1, b2, v1);
      chk($sformatf("b_speed0_bounce_f%0d", f), 32'(b1), 0);
    end
    pix_chk("b_speed0_origin", 1, 0, 0, GREEN);
    pix_chk("b_speed0_right", 1, 64, 32, 6'b000000);

    // Short screen: box1 reflects off the floor and slides under box0.
    speed = 4'd8;
    for (int u = 1; u <= 9; u++) begin
      frame(2, b1, b2, v1);
      chk($sformatf("c_bounce_u%0d", u), 32'(b1), 32'(u == 8));
      if (u == 8) chk("c_pulse_end", 32'(b2), 0);
    end
    pix_chk("c_overlap_box0_wins", 2, 100, 125, WHITE);
    pix_chk("c_box1_only", 2, 60, 125, GREEN);
    pix_chk("c_neither", 2, 140, 125, 6'b000000);

    // Default instance, speed 5: box0 reaches x=570 after 114 updates.
    speed = 4'd5;
    for (int u = 1; u <= 114; u++) begin
      frame(0, b1, b2, v1);
      chk($sformatf("a_bounce_u%0d", u), 32'(b1), 32'(u == 26 || u == 71 || u == 84));
      if (u == 26 || u == 71 || u == 84) chk($sformatf("a_pulse_end_u%0d", u), 32'(b2), 0);
      if (u == 1) begin
        chk("vsync_d_hi", 32'(v1), 1);
        chk("vsync_d_lo", 32'(vs_a), 0);
      end
    end
    pix_chk("a_u114_box0", 0, 570, 270, RED);
    pix_chk("a_u114_box0_left", 0, 569, 270, 6'b000000);
    pix_chk("a_u114_box1", 0, 440, 210, YELLOW);
    pix_chk("a_u114_box1_left", 0, 439, 210, 6'b000000);
    pix_chk("a_u114_box1_far", 0, 503, 264, YELLOW);
    pix_chk("a_u114_box1_right", 0, 504, 210, 6'b000000);

    frame(0, b1, b2, v1);
    chk("a_u115_bounce", 32'(b1), 0);
    pix_chk("a_u115_box0", 0, 575, 270, RED);
    frame(0, b1, b2, v1);
    chk("a_u116_bounce", 32'(b1), 1);
    chk("a_u116_pulse_end", 32'(b2), 0);
    pix_chk("a_u116_box0", 0, 576, 260, GREEN);
    pix_chk("a_u116_box0_left", 0, 575, 260, 6'b000000);
    pix_chk("a_u116_box_over_border", 0, 639, 260, GREEN);
    pix_chk("a_border_x1", 0, 1, 100, BRD);
    probe(0, 576, 260, 1'b0, v);
    chk("a_blank", 32'(v), 0);

    // Asynchronous reset in the middle of a vsync pulse.
    pix_x = 10'd576; pix_y = 10'd260; video_active = 1'b1;
    vsync_a = 1'b1;
    @(negedge clk);
    chk("a_pre_rst_rgb", 32'(rgb_a), 32'(GREEN));
    chk("a_pre_rst_vsync", 32'(vs_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_rst_rgb", 32'(rgb_a), 0);
    chk("a_async_rst_vsync", 32'(vs_a), 0);
    chk("a_async_rst_bounce", 32'(bounce_a), 0);
    vsync_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_post_rst_bounce", 32'(bounce_a), 0);
    pix_chk("a_post_rst_box0", 0, 0, 0, WHITE);
    pix_chk("a_post_rst_box1", 0, 128, 64, RED);
    pix_chk("a_post_rst_box1_left", 0, 127, 70, 6'b000000);
    frame(0, b1, b2, v1);
    chk("a_post_rst_first_bounce", 32'(b1), 0);
    pix_chk("a_post_rst_box0_moved", 0, 5, 10, WHITE);
    pix_chk("a_post_rst_box0_left", 0, 4, 10, 6'b000000);
    pix_chk("a_post_rst_box1_moved", 0, 123, 70, RED);
    pix_chk("a_post_rst_box1_gap", 0, 122, 70, 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_box_bouncer.md
Name: vga_box_bouncer

Overview:
- Parametrised successor to the single bouncing-square demo.
- Animates NUM_BOXES independent boxes inside the visible area.
- Motion runs in the system clock domain: vsync edge detect plus a frame divider, not a vsync-clocked register.
- Adds a runtime speed input, pause, per-box colour cycling on each wall bounce, a bounce pulse output, and a registered pixel output with matched sync delay.
- Sits between hvsync_generator and the TinyVGA PMOD output mapping in the top level.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- BOX_SIZE, 64, box edge length in pixels; requires 4 ≤ BOX_SIZE ≤ V_RES/2
- NUM_BOXES, 2, box count, legal range 1..4
- FRAME_DIV, 1, number of frames per motion update, legal range 1..16
- BORDER, 2, width in pixels of the blue screen border
- SPEED_W, 4, width of the speed input

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hsync_in  in  1  hsync from hvsync_generator
- vsync_in  in  1  vsync from hvsync_generator
- video_active  in  1  display_on from hvsync_generator
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- speed  in  SPEED_W  pixels moved per update, applied to both axes; 0 freezes motion
- pause  in  1  1 = hold all positions and the frame divider
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered
- hsync_out  out  1  hsync_in delayed by 1 clock
- vsync_out  out  1  vsync_in delayed by 1 clock
- bounce  out  1  one-clock pulse when any box reflected on the current update

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rgb=0, hsync_out=0, vsync_out=0, bounce=0.
  - Frame divider count=0, vsync_d=0.
  - Box i: x=2·i·BOX_SIZE, y=i·BOX_SIZE, dx=i[0] (0=right, 1=left), dy=0 (0=down), colour index=i.
- Frame tick: vsync_in=1 while vsync_d=0. vsync_d is registered from vsync_in every clock.
- Frame divider:
  - Advances on each tick while pause=0.
  - Wraps from FRAME_DIV-1 to 0.
  - An update fires on the tick where count==FRAME_DIV-1. FRAME_DIV=1 gives an update every frame.
- Pause: with pause=1, no update fires and the count holds. Ticks that occur while paused are lost, not queued.
- Update, per axis per box, computed at 11-bit width with no wrap:
  - Moving right/down: if pos+BOX_SIZE+speed ≥ RES, then pos=RES−BOX_SIZE, flip direction, count a bounce. Otherwise pos+=speed.
  - Moving left/up: if pos < speed, then pos=0, flip direction, count a bounce. Otherwise pos−=speed.
  - speed=0: positions are unchanged and no bounce is counted.
- Corner case: if both axes bounce in the same update, the colour index increments once (mod 4) and a single bounce pulse is generated.
- bounce: asserted for exactly one clock, the cycle after the update, if any box bounced.
- Pixel path: one cycle of latency.
  - Inside box i: pix_x ∈ [x, x+BOX_SIZE) and pix_y ∈ [y, y+BOX_SIZE).
  - Priority: the lowest index box wins, then the border, then black.
  - Border: pix_x<BORDER, pix_x≥H_RES−BORDER, pix_y<BORDER, or pix_y≥V_RES−BORDER. Colour 6'b000011.
  - Box colour: PALETTE[colour index].
  - rgb=0 when video_active=0.
- Positions and colour indices change only on update cycles. This happens during vsync, so no tearing occurs within a frame.
- Reset mid-frame or mid-update: all state returns to reset values immediately. The first update follows the first full tick sequence after release.

Decomposition:
- Package vga_box_pkg holds:
  - H_RES_DEF, V_RES_DEF.
  - Direction encodings DIR_POS=0 and DIR_NEG=1.
  - The 4-entry 6-bit palette: 0=6'b111111 white, 1=6'b110000 red, 2=6'b001100 green, 3=6'b111100 yellow.
  - BORDER_COLOUR.
- Sub-module vga_box_motion:
  - One instance per box via generate.
  - Holds x, y, dx, dy and colour index for its box.
  - Inputs: update, speed, reset position/direction/colour parameters. Outputs: position, colour, bounced.
- The top-level block owns the tick/divider logic, the priority mux and the output registers.

Test Plan:
- Reset release with NUM_BOXES=2, BOX_SIZE=64 → box0 at (0,0) dx=0; box1 at (128,64) dx=1; rgb=0; bounce=0.
- speed=5, FRAME_DIV=1, box0 at x=570 dx=0:
  - Update 1 → x=575, no bounce.
  - Update 2 → x=576, dx=1, colour 0→1, bounce high for exactly 1 clock.
- speed=5, box0 at x=3 dx=1, y=411 dy=0 → x=0, dx=0, y=416, dy=1; colour increments by 1 only; a single bounce pulse.
- FRAME_DIV=3, speed=2, pause=0 → x changes by 2 only on every third vsync rising edge. Then pause=1 for 5 frames → x unchanged and divider count held.
- Pixel mux:
  - Box0 overlapping box1 at the same pixel → rgb=PALETTE[box0 colour] one clock after pix_x/pix_y.
  - pix_x=1 outside boxes → 6'b000011.
  - video_active=0 → 6'b000000.
  - hsync_out/vsync_out equal the inputs delayed by 1 clock.
- Assert rst_n=0 mid-frame during motion → all outputs 0 asynchronously; positions back to reset values; no spurious bounce after release.
